// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit framer (BREAK states exist only with UART_TX_BREAK_EN)
package uart_pkg;
  localparam int MAX_DATA_W = 9;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD} parity_e;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
`ifdef UART_TX_BREAK_EN
    BREAK,
    BRK_STOP,
`endif
    STOP
  } tx_state_e;
  function automatic int frame_len(int data_w, parity_e parity, logic stop2);
    return 1 + data_w + ((parity == PAR_EVEN || parity == PAR_ODD) ? 1 : 0) + (stop2 ? 2 : 1);
  endfunction
endpackage

// File: rtl/uart_tx_hold.sv
// uart_tx_hold: one-entry holding buffer; an empty buffer lets a word bypass straight into the shifter
module uart_tx_hold
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              block,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              avail,
  output logic [DATA_W-1:0] word
);
  logic              full;
  logic              accept;
  logic [DATA_W-1:0] hold_q;
  always_comb begin
    ready = !full && !block;
    accept = valid && ready;
    avail = full || accept;
    word = full ? hold_q : data;
  end
  always_ff @(posedge clk)
    if (rst) full <= 1'b0;
    else full <= full ? !load : accept && !load;
  always_ff @(posedge clk)
    if (accept) hold_q <= data;
endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: start/data/parity/stop serialiser with a one-word holding buffer; UART_TX_BREAK_EN adds send_break
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int         DATA_W         = 8,
  parameter logic [1:0] DEFAULT_PARITY = 2'b00,
  parameter logic       DEFAULT_STOP2  = 1'b0
) (
  input  logic              baud_clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cfg_override,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
`ifdef UART_TX_BREAK_EN
  input  logic              send_break,
`endif
  output logic              active_flag,
  output logic              done_flag,
  output logic              data_tx
);
  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);
  localparam logic [3:0] BRK_LAST = 4'(DATA_W + 1);
  tx_state_e         state, state_d;
  parity_e           mode;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] shift_q, word;
  logic              par_q, par_en_q, stop2_q;
  logic              load, avail, block, last_stop, brk_done;
  uart_tx_hold #(.DATA_W(DATA_W)) u_hold (
    .clk  (baud_clk),
    .rst  (rst),
    .valid(tx_valid),
    .block(block),
    .load (load),
    .data (tx_data),
    .ready(tx_ready),
    .avail(avail),
    .word (word)
  );
`ifdef UART_TX_BREAK_EN
  assign block = state == BREAK;
  assign brk_done = state == BRK_STOP;
`else
  assign block = 1'b0;
  assign brk_done = 1'b0;
`endif
  always_comb begin
    mode = parity_e'(cfg_override ? cfg_parity : DEFAULT_PARITY);
    last_stop = state == STOP && (!stop2_q || cnt == 4'd1);
    state_d = state;
    load = 1'b0;
    case (state)
`ifdef UART_TX_BREAK_EN
      IDLE: begin
        load = avail && !send_break;
        state_d = send_break ? BREAK : avail ? START : IDLE;
      end
      BREAK: state_d = (cnt >= BRK_LAST && !send_break) ? BRK_STOP : BREAK;
      BRK_STOP: state_d = IDLE;
`else
      IDLE: begin
        load = avail;
        state_d = avail ? START : IDLE;
      end
`endif
      START: state_d = DATA;
      DATA: state_d = cnt == LAST_BIT ? (par_en_q ? PARITY : STOP) : DATA;
      PARITY: state_d = STOP;
      STOP: if (last_stop) begin
        // the next word, buffered or arriving now, starts without an idle gap
        load = avail;
        state_d = avail ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    data_tx = (state == START || block) ? 1'b0 : state == DATA ? shift_q[0] : state == PARITY ? par_q : 1'b1;
    active_flag = state != IDLE;
    done_flag = last_stop || brk_done;
  end
  always_ff @(posedge baud_clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= state_d != state ? '0 : cnt == 4'hf ? cnt : cnt + 4'd1;
      if (load) begin
        shift_q <= word;
        par_q <= ^word ^ (mode == PAR_ODD);
        par_en_q <= mode == PAR_EVEN || mode == PAR_ODD;
        stop2_q <= cfg_override ? cfg_stop2 : DEFAULT_STOP2;
      end else if (state == DATA) shift_q <= shift_q >> 1;
    end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: scoreboard bench for the 8-bit framer plus a 5-bit odd/stop2 instance
module tb_uart_tx_framer;
  logic       baud_clk = 0, rst = 1, tx_valid = 0, cfg_override = 0, cfg_stop2 = 0, send_break = 0;
  logic [7:0] tx_data = 0;
  logic [1:0] cfg_parity = 0;
  logic       tx_ready, active_flag, done_flag, data_tx;
  logic       v5 = 0;
  logic [4:0] d5 = 0;
  logic       r5, a5, dn5, tx5;
  logic [1:0] q[$], q5[$];
  logic [1:0] e, e5;
  int         passed = 0, total = 0, run = 0, last_run = 0;
  logic       ready_low;
  logic [7:0] words[3] = '{8'h01, 8'h02, 8'h03};

  always #5 baud_clk = ~baud_clk;

  uart_tx_framer #(.DATA_W(8)) dut (
    .baud_clk(baud_clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .cfg_override(cfg_override), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
`ifdef UART_TX_BREAK_EN
    .send_break(send_break),
`endif
    .active_flag(active_flag), .done_flag(done_flag), .data_tx(data_tx)
  );

  uart_tx_framer #(.DATA_W(5), .DEFAULT_PARITY(2'b10), .DEFAULT_STOP2(1'b1)) dut5 (
    .baud_clk(baud_clk), .rst(rst), .tx_valid(v5), .tx_ready(r5), .tx_data(d5),
    .cfg_override(1'b0), .cfg_parity(2'b00), .cfg_stop2(1'b0),
`ifdef UART_TX_BREAK_EN
    .send_break(1'b0),
`endif
    .active_flag(a5), .done_flag(dn5), .data_tx(tx5)
  );

  function automatic void check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // expected {data_tx, done_flag} per active cycle; par: 0 none, 1 even, 2 odd
  function automatic void push_frame(logic [7:0] d, int par, bit stop2);
    q.push_back(2'b00);
    for (int i = 0; i < 8; i++) q.push_back({d[i], 1'b0});
    if (par != 0) q.push_back({^d ^ (par == 2), 1'b0});
    if (stop2) q.push_back(2'b10);
    q.push_back(2'b11);
  endfunction

  always @(negedge baud_clk) begin
    if (active_flag) begin
      run++;
      if (q.size() == 0) check("unexpected_active", 1, 0);
      else begin
        e = q.pop_front();
        check("data_tx", data_tx, e[1]);
        check("done_flag", done_flag, e[0]);
      end
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  end

  always @(negedge baud_clk)
    if (a5) begin
      if (q5.size() == 0) check("unexpected_active5", 1, 0);
      else begin
        e5 = q5.pop_front();
        check("data_tx5", tx5, e5[1]);
        check("done_flag5", dn5, e5[0]);
      end
    end

  task automatic send(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 100) begin @(negedge baud_clk); n++; end
    check("ready_wait", int'(n < 100), 1);
    tx_data = d;
    tx_valid = 1;
    @(posedge baud_clk);
    @(negedge baud_clk);
    tx_valid = 0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while ((active_flag || a5 || q.size() != 0 || q5.size() != 0) && n < 300) begin
      @(negedge baud_clk);
      n++;
    end
    check({name, "_timeout"}, int'(n < 300), 1);
    @(negedge baud_clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge baud_clk);
    check("rst_data_tx", data_tx, 1);
    check("rst_active", active_flag, 0);
    check("rst_done", done_flag, 0);
    check("rst_ready", tx_ready, 1);
    rst = 0;
    @(negedge baud_clk);
    push_frame(8'hA5, 0, 0);
    send(8'hA5);
    check("latency_start", {active_flag, data_tx}, 2);
    check("bypass_ready", tx_ready, 1);
    wait_idle("a5");
    check("a5_len", last_run, 10);
    cfg_override = 1;
    cfg_parity = 2'b01;
    push_frame(8'hA5, 1, 0);
    send(8'hA5);
    cfg_parity = 2'b10;
    wait_idle("even");
    check("even_len", last_run, 11);
    push_frame(8'hA5, 2, 0);
    send(8'hA5);
    cfg_parity = 2'b00;
    wait_idle("odd");
    check("odd_len", last_run, 11);
    cfg_override = 0;
    push_frame(8'h81, 0, 0);
    send(8'h81);
    repeat (9) @(negedge baud_clk);
    check("last_stop_done", done_flag, 1);
    push_frame(8'h7E, 0, 0);
    send(8'h7E);
    check("direct_load_ready", tx_ready, 1);
    wait_idle("direct");
    check("direct_len", last_run, 20);
    cfg_override = 1;
    cfg_stop2 = 1;
    ready_low = 0;
    for (int i = 0; i < 3; i++) push_frame(words[i], 0, 1);
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      tx_data = words[i];
      tx_valid = 1;
      while (!tx_ready && n < 100) begin @(negedge baud_clk); ready_low = 1; n++; end
      check("b2b_wait", int'(n < 100), 1);
      @(posedge baud_clk);
      @(negedge baud_clk);
    end
    tx_valid = 0;
    check("ready_low_seen", ready_low, 1);
    wait_idle("b2b");
    check("b2b_len", last_run, 33);
    cfg_override = 0;
    cfg_stop2 = 0;
    q.push_back(2'b00);
    q.push_back(2'b00);
    q.push_back(2'b00);
    q.push_back(2'b10);
    send(8'h3C);
    tx_data = 8'h55;
    tx_valid = 1;
    @(posedge baud_clk);
    @(negedge baud_clk);
    tx_valid = 0;
    check("buffered_ready", tx_ready, 0);
    repeat (2) @(negedge baud_clk);
    rst = 1;
    @(negedge baud_clk);
    check("midrst_data_tx", data_tx, 1);
    check("midrst_active", active_flag, 0);
    check("midrst_done", done_flag, 0);
    check("midrst_ready", tx_ready, 1);
    rst = 0;
    repeat (30) @(negedge baud_clk);
    #1;
    check("midrst_run", last_run, 4);
    check("midrst_queue", q.size(), 0);
`ifdef UART_TX_BREAK_EN
    @(negedge baud_clk);
    for (int i = 0; i < 10; i++) q.push_back(2'b00);
    q.push_back(2'b11);
    send_break = 1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge baud_clk);
      if (i == 3) send_break = 0;
      check("break_ready", tx_ready, 0);
    end
    wait_idle("break");
    check("break_len", last_run, 11);
`endif
    @(negedge baud_clk);
    q5 = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b11};
    d5 = 5'h1F;
    v5 = 1;
    @(posedge baud_clk);
    @(negedge baud_clk);
    v5 = 0;
    check("w5_start", {a5, tx5}, 2);
    wait_idle("w5");
    check("final_queue", q.size(), 0);
    check("final_queue5", q5.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Parametrised successor of the fixed 8N1 parallel-in/serial-out transmitter.
- Frames a DATA_W-bit word with a start bit, optional even/odd parity (computed internally) and 1 or 2 stop bits, then shifts it out LSB-first, one bit per baud_clk cycle.
- A one-entry holding buffer behind a valid/ready handshake allows back-to-back frames with zero idle gap.
- Sits between the TX baud generator and the top-level pin.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- DEFAULT_PARITY, 2'b00, parity mode used when cfg_override=0; encoding 00 none, 01 even, 10 odd, 11 treated as none.
- DEFAULT_STOP2, 1'b0, 1 means two stop bits when cfg_override=0.

Ports:
- baud_clk  in  1  bit clock; one serial bit per cycle.
- rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  tx_data is offered.
- tx_ready  out  1  holding buffer can accept a word.
- tx_data  in  DATA_W  word to transmit.
- cfg_override  in  1  1 selects cfg_parity/cfg_stop2 instead of the parameters.
- cfg_parity  in  2  runtime parity mode, same encoding as DEFAULT_PARITY.
- cfg_stop2  in  1  runtime two-stop-bit select.
- active_flag  out  1  high while any frame bit is being driven.
- done_flag  out  1  one-cycle pulse during the final stop-bit cycle.
- data_tx  out  1  serial line; idle high.

Behaviour:
- Reset values: data_tx=1, active_flag=0, done_flag=0, tx_ready=1. Holding buffer is emptied and the state machine returns to IDLE.
- Handshake:
  - Transfer occurs on a rising edge where tx_valid&&tx_ready.
  - tx_ready = !hold_full, registered.
  - tx_data must be stable while tx_valid=1 and tx_ready=0.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: data_tx=1, active_flag=0. A transfer, or a full buffer, loads the shifter; the next cycle is START.
  - START: data_tx=0 for 1 cycle. active_flag=1 from the start bit through the last stop bit.
  - DATA: DATA_W cycles, bit 0 first; bit counter counts 0..DATA_W-1.
  - PARITY: 1 cycle, present only if the mode is even or odd.
    - Even: bit = XOR of the data bits.
    - Odd: bit = inverted XOR of the data bits.
  - STOP: 1 or 2 cycles with data_tx=1. done_flag=1 in the last stop cycle only.
- Configuration: parity and stop2 are latched at shifter load. Changes mid-frame do not affect the current frame.
- Frame length: 1 + DATA_W + (parity?1:0) + (stop2?2:1) cycles.
- Latency: transfer at edge k with the block idle and the buffer empty gives the start bit at cycle k+1. The word bypasses the buffer and tx_ready stays 1.
- Back-to-back: if the buffer is full in the last stop cycle, the next cycle is START of the buffered word; active_flag stays 1 and there is no idle gap. The buffer empties on that load and tx_ready rises the cycle after.
- Full buffer: tx_ready=0 and tx_valid is ignored, with no overwrite.
- Simultaneous events: a transfer in the last stop cycle while the buffer is empty loads the new word directly into the shifter, with no gap.
- Reset mid-frame: the frame is abandoned; data_tx=1 the next cycle, no done_flag pulse, and the buffered word is discarded.

Optional Feature:
- UART_TX_BREAK_EN defined:
  - Adds input send_break (1 bit).
  - When sampled high in IDLE, enters state BREAK. data_tx=0 and active_flag=1 for as long as send_break stays high, minimum DATA_W+2 cycles.
  - Then 1 stop cycle (data_tx=1) with a done_flag pulse, then IDLE.
  - tx_ready is forced 0 during BREAK.
  - send_break raised mid-frame is deferred until IDLE.
- Undefined: no port and no BREAK state; behaviour is otherwise identical.

Decomposition:
- Package uart_pkg:
  - parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD).
  - tx_state_e enum.
  - localparam MAX_DATA_W=9.
  - Function frame_len(data_w, parity, stop2).
- One sub-module, uart_tx_hold: the one-entry holding buffer with valid/ready in and a load/pop interface to the framer FSM.

Test Plan:
- DATA_W=8, parity none, stop1, send 0xA5 -> data_tx 0,1,0,1,0,0,1,0,1,1; done_flag in cycle 10; active_flag high cycles 1..10.
- 0xA5 with cfg_override=1, cfg_parity=01 (even) then 10 (odd) -> parity bit 0 then 1; frame 11 cycles.
- Three words 0x01, 0x02, 0x03 with tx_valid held high, stop2=1 -> 33 contiguous active cycles, no idle high between frames, tx_ready low while the buffer is full.
- Assert rst in cycle 4 of a frame with a word buffered -> data_tx=1 and active_flag=0 next cycle, no done_flag, tx_ready=1, buffered word never sent.
- DATA_W=5 build, send 5'h1F with odd parity, stop2 -> 0,1,1,1,1,1,0,1,1; done_flag in the last cycle.
- UART_TX_BREAK_EN: send_break high 3 cycles in IDLE -> data_tx=0 for 10 cycles (DATA_W=8 minimum), then 1 with a done_flag pulse; tx_ready=0 throughout.
